// File: rtl/regfile_pkg.sv
// Shared constants and arbiter state encoding for the
// register-file writeback arbiter.
package regfile_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ARB_A_PRI   = 1'b0,
    ARB_B_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_out_reg.sv
// Output register for the register-file write port.
// Ports: clk, rst_n, we/addr/data in; rf_we/rf_waddr/rf_wdata out.
module wb_out_reg
  import regfile_pkg::*;
#(
  parameter int AW = REG_AW,
  parameter int DW = REG_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= we;
      // address/data hold whenever no write is issued
      if (we) begin
        rf_waddr <= addr;
        rf_wdata <= data;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single RF write port between WB stage (A, priority)
// and a long-latency unit (B) with a starvation guard forcing one B
// grant after STARVE_LIMIT refused cycles. Output is registered.
// Ports: clk, rst_n; a_valid/a_ready/a_addr/a_data;
// b_valid/b_ready/b_addr/b_data; rf_we/rf_waddr/rf_wdata; b_starved.
// Option: REGFILE_ZERO_DISCARD_EN drops writes to address 0.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int AW = REG_AW,
  parameter int DW = REG_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          b_starved
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_e state, state_nxt;
  logic [3:0] starve_cnt, cnt_nxt;
  logic a_xfer, b_xfer;
  logic we;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    unique case (state)
      ARB_A_PRI: begin
        a_ready = a_valid;
        b_ready = b_valid && !a_valid;
      end
      ARB_B_FORCE: begin
        b_ready = b_valid;
        a_ready = a_valid && !b_valid;
      end
      default: ;
    endcase
  end

  assign a_xfer = a_valid && a_ready;
  assign b_xfer = b_valid && b_ready;

  always_comb begin
    cnt_nxt = 4'd0;
    if (b_valid && !b_ready)
      cnt_nxt = (starve_cnt == 4'hF) ? 4'hF
                                     : starve_cnt + 4'd1;
  end

  // B_FORCE lasts one cycle: B is either granted or has dropped
  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_A_PRI:
        if (cnt_nxt >= LIMIT) state_nxt = ARB_B_FORCE;
      ARB_B_FORCE:
        state_nxt = ARB_A_PRI;
      default: state_nxt = ARB_A_PRI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_A_PRI;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= cnt_nxt;
    end
  end

  assign b_starved = (state == ARB_B_FORCE);

  always_comb begin
    addr = b_xfer ? b_addr : a_addr;
    data = b_xfer ? b_data : a_data;
`ifdef REGFILE_ZERO_DISCARD_EN
    we = (a_xfer || b_xfer) && (addr != AW'(REG_ZERO));
`else
    we = a_xfer || b_xfer;
`endif
  end

  wb_out_reg #(
    .AW(AW),
    .DW(DW)
  ) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .addr    (addr),
    .data    (data),
    .rf_we   (rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios
// plus randomized traffic against a behavioural arbitration model.
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst_n;
  logic        a_valid, a_ready;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid, b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        b_starved;

  int n_cmp = 0;
  int n_err = 0;

`ifdef REGFILE_ZERO_DISCARD_EN
  localparam bit DISCARD = 1'b1;
`else
  localparam bit DISCARD = 1'b0;
`endif

  regfile_wb_arbiter #(
    .STARVE_LIMIT(LIMIT),
    .AW(5),
    .DW(32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .b_starved(b_starved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 ||
        rf_wdata !== 32'd0 || b_starved !== 1'b0) begin
      n_err++;
      $display("FAIL reset_init: we=%b a=%0d d=%h st=%b want 0",
               rf_we, rf_waddr, rf_wdata, b_starved);
    end
    step();
    rst_n = 1'b1;
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h77;
    step();
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5) begin
      n_err++;
      $display("FAIL reset_pre: we=%b a=%0d want 1/5",
               rf_we, rf_waddr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 ||
        rf_wdata !== 32'd0 || b_starved !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: we=%b a=%0d d=%h st=%b want 0",
               rf_we, rf_waddr, rf_wdata, b_starved);
    end
    n_cmp++;
    if (a_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_aready: got %b want 1", a_ready);
    end
    #1;
    rst_n = 1'b1;
    a_valid = 1'b0;
    step();
    n_cmp++;
    if (rf_we !== 1'b0) begin
      n_err++;
      $display("FAIL reset_lost: rf_we got %b want 0", rf_we);
    end
  endtask

  task automatic test_a_only();
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hDEADBEEF;
    b_valid = 1'b0;
    #1;
    n_cmp++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_err++;
      $display("FAIL a_only_rdy: a=%b b=%b want 1/0",
               a_ready, b_ready);
    end
    step();
    a_valid = 1'b0;
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 ||
        rf_wdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL a_only_wr: we=%b a=%0d d=%h want 1/3/deadbeef",
               rf_we, rf_waddr, rf_wdata);
    end
    step();
    n_cmp++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd3 ||
        rf_wdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL a_only_idle: we=%b a=%0d d=%h want 0/3/deadbeef",
               rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_contention();
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h55;
    for (int i = 1; i <= LIMIT; i++) begin
      a_valid = 1'b1; a_addr = 5'(i); a_data = 32'(i);
      #1;
      n_cmp++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0 ||
          b_starved !== 1'b0) begin
        n_err++;
        $display("FAIL cont_wait%0d: a=%b b=%b st=%b want 1/0/0",
                 i, a_ready, b_ready, b_starved);
      end
      step();
      n_cmp++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'(i)) begin
        n_err++;
        $display("FAIL cont_awr%0d: we=%b a=%0d want 1/%0d",
                 i, rf_we, rf_waddr, i);
      end
    end
    a_addr = 5'd5; a_data = 32'd5;
    #1;
    n_cmp++;
    if (b_starved !== 1'b1 || b_ready !== 1'b1 ||
        a_ready !== 1'b0) begin
      n_err++;
      $display("FAIL cont_force: st=%b b=%b a=%b want 1/1/0",
               b_starved, b_ready, a_ready);
    end
    step();
    b_valid = 1'b0;
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 ||
        rf_wdata !== 32'h55 || b_starved !== 1'b0) begin
      n_err++;
      $display("FAIL cont_bwr: we=%b a=%0d d=%h st=%b want 1/7/55/0",
               rf_we, rf_waddr, rf_wdata, b_starved);
    end
    #1;
    n_cmp++;
    if (a_ready !== 1'b1) begin
      n_err++;
      $display("FAIL cont_back: a_ready got %b want 1", a_ready);
    end
    step();
    a_valid = 1'b0;
    step();
  endtask

  task automatic test_same_addr();
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'd1;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'd2;
    #1;
    n_cmp++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_err++;
      $display("FAIL same_rdy: a=%b b=%b want 1/0",
               a_ready, b_ready);
    end
    step();
    a_valid = 1'b0;
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd9 ||
        rf_wdata !== 32'd1) begin
      n_err++;
      $display("FAIL same_first: we=%b a=%0d d=%h want 1/9/1",
               rf_we, rf_waddr, rf_wdata);
    end
    step();
    b_valid = 1'b0;
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd9 ||
        rf_wdata !== 32'd2) begin
      n_err++;
      $display("FAIL same_second: we=%b a=%0d d=%h want 1/9/2",
               rf_we, rf_waddr, rf_wdata);
    end
    step();
  endtask

  task automatic test_b_idle();
    int bad = 0;
    b_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a_valid = 1'b1;
      a_addr = 5'($urandom_range(1, 31));
      a_data = $urandom;
      step();
      n_cmp++;
      if (rf_we !== 1'b1 || b_starved !== 1'b0 ||
          dut.starve_cnt !== 4'd0) begin
        n_err++;
        $display("FAIL b_idle%0d: we=%b st=%b cnt=%0d want 1/0/0",
                 i, rf_we, b_starved, dut.starve_cnt);
      end
    end
    a_valid = 1'b0;
    step();
  endtask

  task automatic test_zero_addr();
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFF;
    #1;
    n_cmp++;
    if (a_ready !== 1'b1) begin
      n_err++;
      $display("FAIL zero_rdy: got %b want 1", a_ready);
    end
    step();
    a_valid = 1'b0;
    n_cmp++;
    if (DISCARD) begin
      if (rf_we !== 1'b0) begin
        n_err++;
        $display("FAIL zero_discard: rf_we got %b want 0", rf_we);
      end
    end else begin
      if (rf_we !== 1'b1 || rf_waddr !== 5'd0 ||
          rf_wdata !== 32'hFF) begin
        n_err++;
        $display("FAIL zero_write: we=%b a=%0d d=%h want 1/0/ff",
                 rf_we, rf_waddr, rf_wdata);
      end
    end
    step();
  endtask

  // Model: B gets the port when A is absent or B has been refused
  // LIMIT cycles in a row (then exactly one forced turn).
  task automatic test_random();
    bit forced = 0;
    int waited = 0;
    bit ga, gb;
    bit e_we = 0;
    logic [4:0]  e_addr = '0;
    logic [31:0] e_data = '0;
    #2;
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    for (int c = 0; c < 600; c++) begin
      a_valid = ($urandom_range(0, 99) < 80);
      a_addr = 5'($urandom_range(0, 31));
      a_data = $urandom;
      if (!b_valid) begin
        b_valid = ($urandom_range(0, 99) < 50);
        b_addr = 5'($urandom_range(0, 31));
        b_data = $urandom;
      end else if ($urandom_range(0, 99) < 3) begin
        b_valid = 1'b0;
      end
      gb = b_valid && (forced || !a_valid);
      ga = a_valid && !gb;
      #1;
      n_cmp++;
      if (a_ready !== ga || b_ready !== gb ||
          b_starved !== forced) begin
        n_err++;
        $display("FAIL rnd_rdy%0d: a=%b b=%b st=%b want %b/%b/%b",
                 c, a_ready, b_ready, b_starved, ga, gb, forced);
      end
      e_we = 0;
      if (ga || gb) begin
        e_we = !(DISCARD && (gb ? b_addr : a_addr) == 5'd0);
        if (e_we) begin
          e_addr = gb ? b_addr : a_addr;
          e_data = gb ? b_data : a_data;
        end
      end
      if (b_valid && !gb) waited = (waited < 15) ? waited + 1 : 15;
      else waited = 0;
      forced = !forced && (waited >= LIMIT);
      step();
      if (gb) b_valid = 1'b0;
      n_cmp++;
      if (rf_we !== e_we || rf_waddr !== e_addr ||
          rf_wdata !== e_data) begin
        n_err++;
        $display("FAIL rnd_wr%0d: %b/%0d/%h want %b/%0d/%h",
                 c, rf_we, rf_waddr, rf_wdata,
                 e_we, e_addr, e_data);
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    test_reset();
    test_a_only();
    test_contention();
    test_same_addr();
    test_b_idle();
    test_zero_addr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
